// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG coefficient path: component tags,
// sequencer states and the zigzag-to-raster address table.
package jpeg_pkg;

  localparam int COEF_W_DEF = 11;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_WAIT_DONE,
    S_NEXT
  } seq_state_t;

  // ZZ[k] = raster address (row*8+col) of the k-th coefficient in zigzag order
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/coef_sequencer_if.sv
// Block-buffer and run-encoder signals of the coefficient sequencer.
// master = sequencer side, slave = buffer/encoder side.
interface coef_sequencer_if #(
  parameter int COEF_W = 11
);
  logic                     blk_valid;
  logic                     blk_release;
  logic [5:0]               mem_addr;
  logic signed [COEF_W-1:0] mem_rdata;
  logic                     enc_ena;
  logic                     enc_rdy;
  logic signed [COEF_W-1:0] enc_in;
  logic                     enc_done;
  logic [1:0]               comp;
  logic                     mcu_done;
  logic                     rst_marker;

  modport master (
    input  blk_valid, mem_rdata, enc_rdy, enc_done,
    output blk_release, mem_addr, enc_ena, enc_in, comp, mcu_done, rst_marker
  );

  modport slave (
    output blk_valid, mem_rdata, enc_rdy, enc_done,
    input  blk_release, mem_addr, enc_ena, enc_in, comp, mcu_done, rst_marker
  );
endinterface

// File: rtl/coef_sequencer_dc_predictor.sv
// Per-component DC predictors: saturated difference of the incoming DC
// against the previous DC of the same component.
module dc_predictor
  import jpeg_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_upd,
  input  comp_t                    i_comp,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic signed [COEF_W-1:0] o_diff
);

  localparam logic signed [COEF_W-1:0] MAX_V = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [COEF_W-1:0] MIN_V = {1'b1, {(COEF_W-1){1'b0}}};

  logic signed [COEF_W-1:0] r_pred [3];
  logic signed [COEF_W-1:0] w_pred;
  logic signed [COEF_W:0]   w_sub;

  assign w_pred = r_pred[i_comp];
  assign w_sub  = {i_coef[COEF_W-1], i_coef} - {w_pred[COEF_W-1], w_pred};

  // the two top bits disagree exactly when the difference overflows COEF_W
  always_comb begin
    o_diff = w_sub[COEF_W-1:0];
    if (w_sub[COEF_W] != w_sub[COEF_W-1]) begin
      o_diff = w_sub[COEF_W] ? MIN_V : MAX_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_pred[i] <= '0;
      end
    end else if (i_upd) begin
      r_pred[i_comp] <= i_coef;
    end
  end

endmodule

// File: rtl/coef_sequencer.sv
// Streams 8x8 blocks from the block buffer to the run encoder in zigzag order,
// DC-differenced per component. Restart markers: define COEF_SEQ_RESTART_EN.
module coef_sequencer
  import jpeg_pkg::*;
#(
  parameter int Y_BLOCKS     = 4,
  parameter int COEF_W       = COEF_W_DEF,
  parameter int RST_INTERVAL = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  coef_sequencer_if.master   bus
);

  if (!(Y_BLOCKS == 1 || Y_BLOCKS == 2 || Y_BLOCKS == 4) || RST_INTERVAL < 1) begin : g_bad_cfg
    $error("coef_sequencer: unsupported Y_BLOCKS or RST_INTERVAL");
  end

  localparam logic [2:0] CB_IDX = 3'(Y_BLOCKS);
  localparam logic [2:0] CR_IDX = 3'(Y_BLOCKS + 1);

  seq_state_t               r_state, w_state_nxt;
  logic [5:0]               r_k;
  logic [5:0]               w_k_nxt;
  logic [2:0]               r_blk_cnt;
  logic                     r_fs_pend;
  logic                     w_ena, w_fire, w_last_blk, w_fs_apply;
  logic                     w_mcu_done, w_rst_mark, w_pred_clr;
  comp_t                    w_comp;
  logic signed [COEF_W-1:0] w_diff;

  assign w_ena      = (r_state == S_STREAM);
  assign w_fire     = w_ena && bus.enc_rdy;
  assign w_k_nxt    = w_fire ? r_k + 6'd1 : r_k;
  assign w_last_blk = (r_blk_cnt == CR_IDX);
  assign w_mcu_done = (r_state == S_NEXT) && w_last_blk;
  // a frame_start seen mid-block waits here until the block is retired
  assign w_fs_apply = (frame_start || r_fs_pend) &&
                      (r_state == S_IDLE || r_state == S_NEXT);

  always_comb begin
    w_comp = COMP_CR;
    if (r_blk_cnt < CB_IDX)       w_comp = COMP_Y;
    else if (r_blk_cnt == CB_IDX) w_comp = COMP_CB;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (bus.blk_valid) w_state_nxt = S_PRIME;
      S_PRIME:     w_state_nxt = S_STREAM;
      S_STREAM:    if (w_fire && r_k == 6'd63)
                     w_state_nxt = bus.enc_done ? S_NEXT : S_WAIT_DONE;
      S_WAIT_DONE: if (bus.enc_done) w_state_nxt = S_NEXT;
      S_NEXT:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_blk_cnt <= '0;
      r_fs_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) r_k <= r_k + 6'd1;
      if (w_fs_apply)             r_blk_cnt <= '0;
      else if (r_state == S_NEXT) r_blk_cnt <= w_last_blk ? 3'd0 : r_blk_cnt + 3'd1;
      if (w_fs_apply)       r_fs_pend <= 1'b0;
      else if (frame_start) r_fs_pend <= 1'b1;
    end
  end

`ifdef COEF_SEQ_RESTART_EN
  logic [15:0] r_mcu_cnt;

  assign w_rst_mark = w_mcu_done && (r_mcu_cnt == 16'(RST_INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || w_fs_apply || w_rst_mark) r_mcu_cnt <= '0;
    else if (w_mcu_done)                    r_mcu_cnt <= r_mcu_cnt + 16'd1;
  end
`else
  assign w_rst_mark = 1'b0;
`endif

  assign w_pred_clr = w_fs_apply || w_rst_mark;

  dc_predictor #(.COEF_W(COEF_W)) u_dc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_pred_clr),
    .i_upd  (w_fire && r_k == 6'd0),
    .i_comp (w_comp),
    .i_coef (bus.mem_rdata),
    .o_diff (w_diff)
  );

  assign bus.mem_addr    = ZZ[w_k_nxt];
  assign bus.enc_ena     = w_ena;
  assign bus.enc_in      = !w_ena ? '0 : (r_k == 6'd0) ? w_diff : bus.mem_rdata;
  assign bus.comp        = w_comp;
  assign bus.blk_release = (r_state == S_NEXT);
  assign bus.mcu_done    = w_mcu_done;
  assign bus.rst_marker  = w_rst_mark;

endmodule

// File: doc/coef_sequencer.md
Name: coef_sequencer

Overview:
- Feeds quantised 8x8 coefficient blocks from a ping-pong block buffer into the JPEG run-length encoder, one coefficient per handshake, in zigzag order.
- Replaces each block's DC coefficient with its difference from the previous DC of the same component.
- Steps through MCU component order (Y x Y_BLOCKS, Cb, Cr) and tags every block with its component for Huffman table selection.
- Sits between the block buffer and the run encoder; throttled by the encoder's ready output.

Parameters:
- Y_BLOCKS, 4, luminance blocks per MCU (legal values 1, 2, 4).
- COEF_W, 11, signed coefficient width.
- RST_INTERVAL, 8, MCUs per restart interval. Used only with COEF_SEQ_RESTART_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse; clears DC predictors and component/MCU counters
- blk_valid  in  1  block buffer holds a complete block
- blk_release  out  1  one-cycle pulse; current buffer half consumed
- mem_addr  out  6  raster address into the block buffer
- mem_rdata  in  COEF_W  signed coefficient; valid one cycle after mem_addr
- enc_ena  out  1  coefficient presented to encoder (its ena_in)
- enc_rdy  in  1  encoder ready (its rdy_out)
- enc_in  out  COEF_W  coefficient or DC difference
- enc_done  in  1  encoder block-complete pulse
- comp  out  2  0=Y, 1=Cb, 2=Cr; stable for the whole block
- mcu_done  out  1  one-cycle pulse after the Cr block is released
- rst_marker  out  1  restart pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, k=0, blk_cnt=0, comp=0, DC predictors=0, MCU count=0. All pulse outputs and enc_ena are 0; mem_addr=0; enc_in=0.
- Reset mid-block abandons the block: no blk_release pulse, and the buffer half is not consumed.
- k (0..63) is the zigzag index of the coefficient currently on mem_rdata.
- mem_addr = ZZ[k_next] (combinational), where k_next = k+1 when a transfer fires, otherwise k. A held address re-reads the same word, so no skid register is needed.
- Transfer fires when enc_ena && enc_rdy. enc_ena = (state==STREAM); there is no combinational path from enc_rdy to enc_ena.
- States:
  - IDLE: on blk_valid, drive ZZ[0] and go to PRIME.
  - PRIME: one cycle for read latency, then STREAM.
  - STREAM: one coefficient per fire. On the fire with k=63, go to WAIT_DONE.
  - WAIT_DONE: on enc_done, pulse blk_release and go to NEXT.
  - NEXT: advance blk_cnt; return to IDLE.
- enc_done that coincides with the last fire is recognised immediately (no missed pulse).
- DC (k==0): diff = mem_rdata − pred[comp] at COEF_W+1 bits, saturated to [−2^(COEF_W−1), 2^(COEF_W−1)−1]. pred[comp] <= mem_rdata (unsaturated) on the fire.
- AC (k>0): enc_in = mem_rdata unchanged.
- comp: 0 while blk_cnt<Y_BLOCKS, 1 at Y_BLOCKS, 2 at Y_BLOCKS+1. In NEXT after Cr: blk_cnt wraps to 0 and mcu_done pulses.
- frame_start:
  - In IDLE: clears predictors, blk_cnt and MCU count.
  - Outside IDLE: latched and applied on the next entry to IDLE.
  - If it coincides with NEXT, it wins over the counter advance.
- A blk_valid drop while in STREAM is ignored; the buffer half is owned until blk_release.

Optional Feature:
- COEF_SEQ_RESTART_EN defined: count MCUs. When the count reaches RST_INTERVAL, in the NEXT cycle that completes that MCU:
  - pulse rst_marker alongside mcu_done;
  - zero all predictors;
  - clear the count.
- The next block is not accepted until one cycle after rst_marker, so the marker can be inserted.
- Undefined: rst_marker tied 0; predictors are cleared only by reset and frame_start.

Decomposition:
- Package jpeg_pkg: comp_t enum (COMP_Y, COMP_CB, COMP_CR), seq_state_t enum, the ZZ[64] zigzag constant table, COEF_W default.
- Sub-module dc_predictor: three predictor registers, subtract-and-saturate, clear input. Instantiated once.

Test Plan:
- Block with raster value = index, enc_rdy=1, Y_BLOCKS=1 -> enc_in order 0(DC diff vs 0), 1, 8, 16, 9, 2, …, 63; exactly 64 fires; blk_release one cycle after enc_done.
- Y DC values 100, 90, 95 across three MCUs -> Y DC diffs 100, −10, 5; Cb/Cr predictors independent.
- DC 1023 after predictor −1024 -> enc_in saturates to 1023; DC −1024 after 1023 -> −1024.
- enc_rdy toggled 1,0,0,1 at k=5 -> coefficient at k=5 held stable on enc_in, no duplicate or lost coefficient.
- Y_BLOCKS=4 -> comp sequence 0,0,0,0,1,2; mcu_done after the 6th blk_release. rst_n low at k=30 -> IDLE, no blk_release; the next block restarts at k=0.
- COEF_SEQ_RESTART_EN, RST_INTERVAL=2 -> rst_marker with the 2nd mcu_done; the 3rd MCU's first Y DC diff equals the raw DC.
